// File: rtl/fe_pkg.sv
// Shared types and constants for the following-error monitor.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fe_pkg;

  // Per-channel monitor state
  typedef enum logic [1:0] {
    IDLE,
    OK,
    PENDING,
    FAULT
  } fe_state_t;

  // Config write target select
  localparam logic WR_SEL_THRESH  = 1'b0;
  localparam logic WR_SEL_PERSIST = 1'b1;

  // Largest positive saturated delta; the most-negative code is never produced
  function automatic longint sat_hi(input int delta_w);
    return (longint'(1) << (delta_w - 1)) - 1;
  endfunction

  // Symmetric negative clamp so |delta| always fits in delta_w-1 bits
  function automatic longint sat_lo(input int delta_w);
    return -sat_hi(delta_w);
  endfunction

endpackage

// File: rtl/fe_channel.sv
// One axis: subtract, saturate, threshold compare, persistence FSM, config registers.
// Latency: positions -> delta 2 edges, -> fault 3 edges (persist = 0).
// Backpressure: none; samples every cycle, config writes are single-cycle strobes.
module fe_channel #(
  parameter int POS_W      = 32,
  parameter int DELTA_W    = 16,
  parameter int PERSIST_W  = 8,
  parameter int DEF_THRESH = 40
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic signed [POS_W-1:0]   cmd_pos,
  input  logic signed [POS_W-1:0]   act_pos,
  input  logic                      enable,
  input  logic                      wr_en,
  input  logic                      wr_sel,
  input  logic [DELTA_W-1:0]        wr_data,
  input  logic                      clear,
  output logic signed [DELTA_W-1:0] delta,
  output logic                      fault
);
  import fe_pkg::*;

  localparam logic signed [POS_W:0] SAT_HI = (POS_W+1)'(sat_hi(DELTA_W));
  localparam logic signed [POS_W:0] SAT_LO = (POS_W+1)'(sat_lo(DELTA_W));

  logic signed [POS_W:0]     diff;
  logic signed [DELTA_W-1:0] sat;
  logic [DELTA_W-1:0]        mag;
  logic                      exceed;
  logic [DELTA_W-2:0]        thresh;
  logic [PERSIST_W-1:0]      persist;
  logic [PERSIST_W-1:0]      cnt;
  fe_state_t                 state;

  // Threshold is an unsigned magnitude, so the top write bit carries nothing
  logic unused_wr_msb;
  assign unused_wr_msb = wr_data[DELTA_W-1];

  // Clamp the exact difference into the symmetric delta range and take its magnitude
  always_comb begin
    sat = diff[DELTA_W-1:0];
    if (diff > SAT_HI)
      sat = SAT_HI[DELTA_W-1:0];
    else if (diff < SAT_LO)
      sat = SAT_LO[DELTA_W-1:0];
    mag = sat[DELTA_W-1] ? -sat : sat;
  end

  // Edge 1: sign-extended subtract (exact); edge 2: saturated delta and strict compare
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      diff   <= '0;
      delta  <= '0;
      exceed <= 1'b0;
    end else begin
      diff   <= {cmd_pos[POS_W-1], cmd_pos} - {act_pos[POS_W-1], act_pos};
      delta  <= sat;
      exceed <= mag > {1'b0, thresh};
    end
  end

  // Config registers; a write lands after the compare of its own cycle
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      thresh  <= (DELTA_W-1)'(DEF_THRESH);
      persist <= '0;
    end else if (wr_en) begin
      if (wr_sel == WR_SEL_PERSIST)
        persist <= wr_data[PERSIST_W-1:0];
      else
        thresh <= wr_data[DELTA_W-2:0];
    end
  end

  // Edge 3: persistence FSM; a new fault overrides a same-cycle clear
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      cnt   <= '0;
      fault <= 1'b0;
    end else begin
      if (clear)
        fault <= 1'b0;
      if (!enable) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            state <= OK;
            cnt   <= '0;
          end
          OK: begin
            if (exceed) begin
              if (persist == '0) begin
                state <= FAULT;
                fault <= 1'b1;
              end else begin
                state <= PENDING;
                cnt   <= PERSIST_W'(1);
              end
            end
          end
          PENDING: begin
            if (!exceed) begin
              state <= OK;
              cnt   <= '0;
            end else if (cnt >= persist) begin
              state <= FAULT;
              fault <= 1'b1;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          FAULT: begin
            if (clear) begin
              state <= OK;
              cnt   <= '0;
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/following_error_monitor.sv
// N-channel following-error monitor with sticky faults and shared active-low interrupt.
// Latency: positions -> fault 3 edges, -> irq_n 4 edges (persist = 0).
// Backpressure: none; free-running pipeline, config writes to absent channels are dropped.
module following_error_monitor #(
  parameter int CHANNELS   = 2,
  parameter int POS_W      = 32,
  parameter int DELTA_W    = 16,
  parameter int PERSIST_W  = 8,
  parameter int DEF_THRESH = 40
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [CHANNELS*POS_W-1:0]     cmd_pos,
  input  logic [CHANNELS*POS_W-1:0]     act_pos,
  input  logic [CHANNELS-1:0]           enable,
  input  logic                          wr_en,
  input  logic [2:0]                    wr_chan,
  input  logic                          wr_sel,
  input  logic [DELTA_W-1:0]            wr_data,
  input  logic [CHANNELS-1:0]           clear,
  output logic [CHANNELS*DELTA_W-1:0]   delta,
  output logic [CHANNELS-1:0]           fault,
  output logic                          irq_n
);
  import fe_pkg::*;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    logic chan_wr;
    assign chan_wr = wr_en && (wr_chan == 3'(i));

    fe_channel #(
      .POS_W      (POS_W),
      .DELTA_W    (DELTA_W),
      .PERSIST_W  (PERSIST_W),
      .DEF_THRESH (DEF_THRESH)
    ) u_chan (
      .clk     (clk),
      .resetn  (resetn),
      .cmd_pos (cmd_pos[i*POS_W +: POS_W]),
      .act_pos (act_pos[i*POS_W +: POS_W]),
      .enable  (enable[i]),
      .wr_en   (chan_wr),
      .wr_sel  (wr_sel),
      .wr_data (wr_data),
      .clear   (clear[i]),
      .delta   (delta[i*DELTA_W +: DELTA_W]),
      .fault   (fault[i])
    );
  end

  // Edge 4: interrupt is low while any channel holds a fault
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      irq_n <= 1'b1;
    else
      irq_n <= ~|fault;
  end

endmodule

// File: tb/tb_following_error_monitor.sv
module tb_following_error_monitor;
  localparam int CH = 2;
  localparam int PW = 32;
  localparam int DW = 16;

  logic           clk = 1'b0;
  logic           resetn = 1'b1;
  logic [CH*PW-1:0] cmd_pos = '0;
  logic [CH*PW-1:0] act_pos = '0;
  logic [CH-1:0]  enable = '0;
  logic           wr_en = 1'b0;
  logic [2:0]     wr_chan = '0;
  logic           wr_sel = 1'b0;
  logic [DW-1:0]  wr_data = '0;
  logic [CH-1:0]  clear = '0;
  logic [CH*DW-1:0] delta;
  logic [CH-1:0]  fault;
  logic           irq_n;

  int checks = 0;
  int failures = 0;
  bit cmp_on = 1'b0;

  following_error_monitor dut (
    .clk(clk), .resetn(resetn), .cmd_pos(cmd_pos), .act_pos(act_pos),
    .enable(enable), .wr_en(wr_en), .wr_chan(wr_chan), .wr_sel(wr_sel),
    .wr_data(wr_data), .clear(clear), .delta(delta), .fault(fault), .irq_n(irq_n)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Per channel: pipeline values, a run length of consecutive over-threshold
  // samples, whether the channel is being watched, whether it is parked on a
  // latched fault, and the visible sticky flag.
  longint m_dq[CH];
  longint m_dlt[CH];
  bit     m_exc[CH];
  bit     m_mon[CH];
  bit     m_lat[CH];
  bit     m_flt[CH];
  int     m_run[CH];
  int     m_thr[CH];
  int     m_per[CH];
  bit     m_irq;

  function automatic longint sat16(input longint d);
    if (d > 32767) return 32767;
    if (d < -32767) return -32767;
    return d;
  endfunction

  always @(posedge clk or negedge resetn) begin
    bit set_now;
    if (!resetn) begin
      for (int i = 0; i < CH; i++) begin
        m_dq[i] = 0; m_dlt[i] = 0; m_exc[i] = 0; m_mon[i] = 0;
        m_lat[i] = 0; m_flt[i] = 0; m_run[i] = 0; m_thr[i] = 40; m_per[i] = 0;
      end
      m_irq = 1;
    end else begin
      m_irq = 1;
      for (int i = 0; i < CH; i++) if (m_flt[i]) m_irq = 0;
      for (int i = 0; i < CH; i++) begin
        set_now = 0;
        if (!enable[i]) begin
          m_mon[i] = 0; m_lat[i] = 0; m_run[i] = 0;
        end else if (!m_mon[i]) begin
          m_mon[i] = 1; m_run[i] = 0;
        end else if (m_lat[i]) begin
          if (clear[i]) begin m_lat[i] = 0; m_run[i] = 0; end
        end else if (m_exc[i]) begin
          // fault on the (persist+1)-th consecutive sample
          if (m_run[i] >= m_per[i]) begin set_now = 1; m_lat[i] = 1; m_run[i] = 0; end
          else m_run[i]++;
        end else begin
          m_run[i] = 0;
        end
        if (set_now) m_flt[i] = 1;
        else if (clear[i]) m_flt[i] = 0;
        m_dlt[i] = sat16(m_dq[i]);
        m_exc[i] = ((m_dlt[i] < 0) ? -m_dlt[i] : m_dlt[i]) > m_thr[i];
        m_dq[i] = longint'($signed(cmd_pos[i*PW +: PW])) - longint'($signed(act_pos[i*PW +: PW]));
        if (wr_en && wr_chan == i) begin
          if (wr_sel) m_per[i] = int'(wr_data[7:0]);
          else m_thr[i] = int'(wr_data[14:0]);
        end
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (cmp_on) begin
      for (int i = 0; i < CH; i++) begin
        chk($sformatf("model_delta%0d", i), longint'($signed(delta[i*DW +: DW])), m_dlt[i]);
        chk($sformatf("model_fault%0d", i), longint'(fault[i]), longint'(m_flt[i]));
      end
      chk("model_irq_n", longint'(irq_n), longint'(m_irq));
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_pos(input int ch, input logic [31:0] c, input logic [31:0] a);
    cmd_pos[ch*PW +: PW] = c;
    act_pos[ch*PW +: PW] = a;
  endtask

  task automatic wr(input int ch, input bit sel, input int val);
    wr_en = 1'b1; wr_chan = 3'(ch); wr_sel = sel; wr_data = 16'(val);
    cyc(1);
    wr_en = 1'b0;
  endtask

  task automatic pulse_clr(input logic [1:0] m);
    clear = m;
    cyc(1);
    clear = '0;
  endtask

  initial begin
    #1 resetn = 1'b0;
    cyc(2);
    cmp_on = 1'b1;
    chk("rst_delta", longint'(delta), 0);
    chk("rst_fault", longint'(fault), 0);
    chk("rst_irq_n", longint'(irq_n), 1);
    resetn = 1'b1;
    enable = 2'b11;
    cyc(10);
    chk("quiet_fault", longint'(fault), 0);
    chk("quiet_irq_n", longint'(irq_n), 1);
    chk("quiet_delta", longint'(delta), 0);

    // 41 > 40: delta at edge 2, fault at edge 3, irq at edge 4
    set_pos(0, 41, 0);
    cyc(2);
    chk("step_delta_e2", longint'($signed(delta[15:0])), 41);
    chk("step_fault_e2", longint'(fault[0]), 0);
    cyc(1);
    chk("step_fault_e3", longint'(fault[0]), 1);
    chk("step_irq_e3", longint'(irq_n), 1);
    cyc(1);
    chk("step_irq_e4", longint'(irq_n), 0);
    set_pos(0, 0, 0);
    cyc(3);
    pulse_clr(2'b01);
    chk("clr_fault", longint'(fault[0]), 0);
    chk("clr_irq_lag", longint'(irq_n), 0);
    cyc(1);
    chk("clr_irq", longint'(irq_n), 1);

    // Equal to threshold is not an error
    set_pos(0, 40, 0);
    cyc(6);
    chk("eq_thresh_fault", longint'(fault[0]), 0);
    chk("eq_thresh_delta", longint'($signed(delta[15:0])), 40);
    set_pos(0, 0, 0);

    // Persistence 3 on ch1: 3 samples no fault, 4 samples fault
    wr(1, 1'b1, 3);
    set_pos(1, 100, 0);
    cyc(3);
    set_pos(1, 0, 0);
    cyc(6);
    chk("persist3_short", longint'(fault[1]), 0);
    set_pos(1, 100, 0);
    cyc(4);
    set_pos(1, 0, 0);
    cyc(1);
    chk("persist4_before", longint'(fault[1]), 0);
    cyc(1);
    chk("persist4_fault", longint'(fault[1]), 1);
    cyc(2);
    pulse_clr(2'b10);

    // Extreme positions: exact difference, symmetric saturation
    set_pos(0, 32'h7FFF_FFFF, 32'h8000_0000);
    cyc(2);
    chk("sat_pos", longint'(delta[15:0]), 32'h7FFF);
    cyc(1);
    chk("sat_pos_fault", longint'(fault[0]), 1);
    set_pos(0, 32'h8000_0000, 32'h7FFF_FFFF);
    cyc(2);
    chk("sat_neg", longint'(delta[15:0]), 32'h8001);
    set_pos(0, 0, 0);
    cyc(3);
    pulse_clr(2'b01);

    // Clear while the error persists: re-asserts next edge
    set_pos(0, 100, 0);
    cyc(3);
    chk("persist_err_fault", longint'(fault[0]), 1);
    pulse_clr(2'b01);
    chk("persist_err_cleared", longint'(fault[0]), 0);
    cyc(1);
    chk("persist_err_reassert", longint'(fault[0]), 1);
    set_pos(0, 0, 0);
    cyc(3);
    pulse_clr(2'b01);
    cyc(2);

    // Clear on the same edge as a new fault: fault wins
    set_pos(0, 100, 0);
    cyc(2);
    clear = 2'b01;
    cyc(1);
    clear = '0;
    chk("clr_vs_new_fault", longint'(fault[0]), 1);
    set_pos(0, 0, 0);
    cyc(3);
    pulse_clr(2'b01);

    // Threshold write on the compare edge takes effect one edge later
    set_pos(0, 100, 0);
    cyc(1);
    wr(0, 1'b0, 200);
    cyc(1);
    chk("wr_timing_fault", longint'(fault[0]), 1);
    pulse_clr(2'b01);
    cyc(3);
    chk("new_thresh_quiet", longint'(fault[0]), 0);
    wr(5, 1'b0, 0);
    cyc(3);
    chk("bad_chan_ignored", longint'(fault), 0);
    wr(0, 1'b0, 40);
    set_pos(0, 0, 0);
    cyc(3);

    // Disabled channel keeps its fault until cleared
    set_pos(0, 100, 0);
    cyc(3);
    enable[0] = 1'b0;
    set_pos(0, 0, 0);
    cyc(2);
    chk("idle_keeps_fault", longint'(fault[0]), 1);
    pulse_clr(2'b01);
    chk("idle_clear", longint'(fault[0]), 0);
    enable[0] = 1'b1;
    cyc(3);

    // Lowering persistence while pending faults on the next sample
    wr(1, 1'b1, 5);
    set_pos(1, 100, 0);
    cyc(4);
    wr(1, 1'b1, 1);
    chk("persist_lower_pending", longint'(fault[1]), 0);
    cyc(1);
    chk("persist_lower_fault", longint'(fault[1]), 1);

    // Async reset mid-operation: ch0 pending, ch1 faulted
    wr(0, 1'b1, 5);
    set_pos(0, 100, 0);
    cyc(4);
    chk("pre_rst_fault1", longint'(fault[1]), 1);
    #2 resetn = 1'b0;
    #1;
    chk("mid_rst_fault", longint'(fault), 0);
    chk("mid_rst_irq_n", longint'(irq_n), 1);
    chk("mid_rst_delta", longint'(delta), 0);
    @(negedge clk);
    resetn = 1'b1;
    set_pos(0, 41, 0);
    set_pos(1, 40, 0);
    cyc(3);
    chk("post_rst_thresh", longint'(fault), 1);
    cyc(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
